// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state encoding and control-register bit positions for the capture block
package capture_pkg;

   typedef enum logic [1:0] {
      CAP_IDLE    = 2'd0,
      CAP_ARMED   = 2'd1,
      CAP_CAPTURE = 2'd2,
      CAP_DONE    = 2'd3
   } cap_state_t;

   localparam int CTRL_ARM_BIT   = 2;
   localparam int CTRL_ABORT_BIT = 3;

endpackage

// File: rtl/capture_if.sv
// rtl/capture_if.sv - MAC stream sink plus SDRAM write-master signals of the capture block
interface capture_if #(
   parameter int N = 32
) ();

   logic         st_valid;
   logic [N-1:0] st_data;
   logic         st_sop;
   logic         st_eop;
   logic         st_ready;
   logic [N-1:0] m_address;
   logic         m_write;
   logic [N-1:0] m_writedata;
   logic         m_waitrequest;

   modport master (
      input  st_valid, st_data, st_sop, st_eop, m_waitrequest,
      output st_ready, m_address, m_write, m_writedata
   );

   modport slave (
      output st_valid, st_data, st_sop, st_eop, m_waitrequest,
      input  st_ready, m_address, m_write, m_writedata
   );

endinterface

// File: rtl/capture_wbuf.sv
// rtl/capture_wbuf.sv - one-entry write holding register driving the SDRAM write master
module capture_wbuf #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] base,
   input  logic [N-1:0] offset,
   input  logic [N-1:0] data,
   input  logic         waitrequest,
   output logic         busy,
   output logic [N-1:0] address,
   output logic [N-1:0] writedata,
   output logic         complete
);

   assign complete = busy & ~waitrequest;

   // A load may land on the same cycle the previous write completes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy      <= 1'b0;
         address   <= '0;
         writedata <= '0;
      end else if (load) begin
         busy      <= 1'b1;
         address   <= base + offset;
         writedata <= data;
      end else if (complete) begin
         busy <= 1'b0;
      end
   end

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - capture sequencer: one MAC packet into an SDRAM buffer
module capture_ctrl
   import capture_pkg::*;
#(
   parameter int N     = 32,
   parameter int BYTES = N / 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] cfg_control,
   input  logic [N-1:0] cfg_write_addr,
   input  logic [N-1:0] cfg_max_len,
   capture_if.master    bus,
   output logic [1:0]   state,
   output logic [N-1:0] cap_len,
   output logic         truncated
);

   localparam logic [N:0] STRIDE = (N+1)'(BYTES);

   cap_state_t   state_q, state_d;
   logic [N-1:0] base_q, max_q;
   logic         pkt_end_q;
   logic         arm, abort, ready, accept, take, load, complete, drain_ok, overflow;
   logic         trunc_set, pkt_end_set, latch_cfg;
   logic [N:0]   pending;
   logic         unused_ctrl;

   assign arm         = cfg_control[CTRL_ARM_BIT];
   assign abort       = cfg_control[CTRL_ABORT_BIT];
   assign unused_ctrl = ^{cfg_control[N-1:CTRL_ABORT_BIT+1], cfg_control[CTRL_ARM_BIT-1:0]};
   assign state       = state_q;

   // Bytes committed so far, counting a write still sitting in the buffer.
   assign pending     = {1'b0, cap_len} + (bus.m_write ? STRIDE : '0);
   assign overflow    = (pending + STRIDE) > {1'b0, max_q};
   assign drain_ok    = ~bus.m_write | complete;
   assign accept      = bus.st_valid & bus.st_ready;
   assign load        = take & ~overflow;
   assign trunc_set   = take & overflow;
   assign pkt_end_set = take & bus.st_eop;

   capture_wbuf #(.N(N)) u_wbuf (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .base        (base_q),
      .offset      (pending[N-1:0]),
      .data        (bus.st_data),
      .waitrequest (bus.m_waitrequest),
      .busy        (bus.m_write),
      .address     (bus.m_address),
      .writedata   (bus.m_writedata),
      .complete    (complete)
   );

   // Once truncated, beats are swallowed regardless of buffer state.
   always_comb begin
      ready = 1'b1;
      if (state_q == CAP_CAPTURE) begin
         if (abort || pkt_end_q) ready = 1'b0;
         else if (!truncated)    ready = drain_ok;
      end
   end

   assign bus.st_ready = reset & ready;

   always_comb begin
      state_d   = state_q;
      take      = 1'b0;
      latch_cfg = 1'b0;
      case (state_q)
         CAP_IDLE: begin
            if (arm && !abort) begin
               state_d   = CAP_ARMED;
               latch_cfg = 1'b1;
            end
         end
         CAP_ARMED: begin
            if (abort) begin
               state_d = CAP_IDLE;
            end else if (accept && bus.st_sop) begin
               state_d = CAP_CAPTURE;
               take    = 1'b1;
            end
         end
         CAP_CAPTURE: begin
            if (abort) begin
               if (drain_ok) state_d = CAP_IDLE;
            end else if (pkt_end_q) begin
               if (drain_ok) state_d = CAP_DONE;
            end else if (accept) begin
               take = 1'b1;
            end
         end
         CAP_DONE: begin
            if (!arm) state_d = CAP_IDLE;
         end
         default: state_d = CAP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= CAP_IDLE;
         base_q    <= '0;
         max_q     <= '0;
         cap_len   <= '0;
         truncated <= 1'b0;
         pkt_end_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (latch_cfg) begin
            base_q    <= cfg_write_addr;
            max_q     <= cfg_max_len;
            cap_len   <= '0;
            truncated <= 1'b0;
            pkt_end_q <= 1'b0;
         end else begin
            if (complete)    cap_len   <= cap_len + STRIDE[N-1:0];
            if (trunc_set)   truncated <= 1'b1;
            if (pkt_end_set) pkt_end_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - directed and randomized checks of capture_ctrl against a packet-level model
module tb_capture_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cfg_control, cfg_write_addr, cfg_max_len;
   logic [1:0]  state;
   logic [31:0] cap_len;
   logic        truncated;

   capture_if #(.N(32)) bus ();

   capture_ctrl #(.N(32), .BYTES(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_control    (cfg_control),
      .cfg_write_addr (cfg_write_addr),
      .cfg_max_len    (cfg_max_len),
      .bus            (bus),
      .state          (state),
      .cap_len        (cap_len),
      .truncated      (truncated)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   // Packet-level model: expected writes in flight, bytes admitted, bytes written.
   wr_t         exp_q[$];
   int          m_state;
   longint      exp_len, admitted, m_max;
   logic [31:0] m_base;
   bit          exp_trunc, eop_seen, started;
   logic [31:0] log_addr[$], log_data[$];
   int          mon_checks, mon_fails, checks, failures;

   bit          rand_wr, hold_wr;
   int          stall_left, stall_at;

   function void mchk(string name, logic [63:0] act, logic [63:0] exp);
      mon_checks++;
      if (act !== exp) begin
         mon_fails++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function void model_take(logic [31:0] d, logic eop);
      wr_t w;
      if (admitted + 4 > m_max) begin
         exp_trunc = 1'b1;
      end else begin
         w.addr = m_base + 32'(admitted);
         w.data = d;
         exp_q.push_back(w);
         admitted += 4;
      end
      if (eop) eop_seen = 1'b1;
   endfunction

   always @(negedge clk) begin : monitor
      bit exp_ready, accept, arm, abort;
      if (bus.m_write === 1'b1 && bus.m_waitrequest === 1'b0) begin
         log_addr.push_back(bus.m_address);
         log_data.push_back(bus.m_writedata);
      end
      if (reset !== 1'b1) begin
         if (started) mchk("st_ready_in_reset", 64'(bus.st_ready), 0);
         started   = 1'b1;
         m_state   = 0;
         exp_len   = 0;
         exp_trunc = 1'b0;
         eop_seen  = 1'b0;
         admitted  = 0;
         exp_q.delete();
      end else if (started) begin
         arm   = cfg_control[2];
         abort = cfg_control[3];
         exp_ready = 1'b1;
         if (m_state == 2) begin
            if (abort || eop_seen) exp_ready = 1'b0;
            else if (!exp_trunc)   exp_ready = (exp_q.size() == 0) || !bus.m_waitrequest;
         end
         mchk("state", 64'(state), 64'(m_state));
         mchk("cap_len", 64'(cap_len), 64'(exp_len));
         mchk("truncated", 64'(truncated), 64'(exp_trunc));
         mchk("st_ready", 64'(bus.st_ready), 64'(exp_ready));
         mchk("m_write", 64'(bus.m_write), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            mchk("m_address", 64'(bus.m_address), 64'(exp_q[0].addr));
            mchk("m_writedata", 64'(bus.m_writedata), 64'(exp_q[0].data));
         end
         accept = bus.st_valid && exp_ready;
         if (exp_q.size() != 0 && !bus.m_waitrequest) begin
            void'(exp_q.pop_front());
            exp_len += 4;
         end
         case (m_state)
            0: if (arm && !abort) begin
                  m_state   = 1;
                  m_base    = cfg_write_addr;
                  m_max     = cfg_max_len;
                  exp_len   = 0;
                  exp_trunc = 1'b0;
                  eop_seen  = 1'b0;
                  admitted  = 0;
               end
            1: if (abort) m_state = 0;
               else if (accept && bus.st_sop) begin
                  m_state = 2;
                  model_take(bus.st_data, bus.st_eop);
               end
            2: if (abort) begin
                  if (exp_q.size() == 0) m_state = 0;
               end else if (eop_seen) begin
                  if (exp_q.size() == 0) m_state = 3;
               end else if (accept) begin
                  model_take(bus.st_data, bus.st_eop);
               end
            default: if (!arm) m_state = 0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (hold_wr && bus.m_write) begin
         bus.m_waitrequest = 1'b1;
      end else if (stall_left > 0 && bus.m_write && log_addr.size() == stall_at) begin
         bus.m_waitrequest = 1'b1;
         stall_left--;
      end else if (rand_wr) begin
         bus.m_waitrequest = ($urandom_range(0, 2) == 0);
      end else begin
         bus.m_waitrequest = 1'b0;
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop);
      bit got = 1'b0;
      bus.st_valid = 1'b1;
      bus.st_data  = d;
      bus.st_sop   = sop;
      bus.st_eop   = eop;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = (bus.st_ready === 1'b1);
         tick();
      end
      bus.st_valid = 1'b0;
      bus.st_sop   = 1'b0;
      bus.st_eop   = 1'b0;
      if (!got) chk("beat_accept_timeout", 0, 1);
   endtask

   task automatic wait_state(input logic [1:0] s, input int lim, input string name);
      for (int i = 0; i < lim && state != s; i++) tick();
      chk(name, 64'(state), 64'(s));
   endtask

   task automatic run_packet(input logic [31:0] base, input logic [31:0] maxl, input int junk,
                             input int n, input logic [31:0] d0, output int snap);
      snap           = log_addr.size();
      cfg_write_addr = base;
      cfg_max_len    = maxl;
      cfg_control    = 32'h4;
      tick();
      for (int j = 0; j < junk; j++) send_beat(32'hC0 + 32'(j), 1'b0, j == junk - 1);
      for (int k = 0; k < n; k++) send_beat(d0 + 32'(k), k == 0, k == n - 1);
      wait_state(2'd3, 200, "reach_done");
   endtask

   task automatic end_capture();
      cfg_control = 32'h0;
      wait_state(2'd0, 10, "back_to_idle");
   endtask

   logic [31:0] t1_addr[4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};

   initial begin
      int snap;
      reset = 1'b0;
      cfg_control = 0; cfg_write_addr = 0; cfg_max_len = 0;
      bus.st_valid = 0; bus.st_data = 0; bus.st_sop = 0; bus.st_eop = 0; bus.m_waitrequest = 0;
      rand_wr = 0; hold_wr = 0; stall_left = 0; stall_at = 0;
      repeat (3) tick();
      chk("rst_state", 64'(state), 0);
      chk("rst_m_write", 64'(bus.m_write), 0);
      chk("rst_m_address", 64'(bus.m_address), 0);
      chk("rst_m_writedata", 64'(bus.m_writedata), 0);
      chk("rst_cap_len", 64'(cap_len), 0);
      chk("rst_truncated", 64'(truncated), 0);
      chk("rst_st_ready", 64'(bus.st_ready), 0);
      reset = 1'b1;
      tick();

      run_packet(32'h1000, 64, 0, 4, 32'hA0, snap);
      chk("t1_writes", 64'(log_addr.size() - snap), 4);
      for (int k = 0; k < 4; k++) begin
         chk("t1_addr", 64'(log_addr[snap + k]), 64'(t1_addr[k]));
         chk("t1_data", 64'(log_data[snap + k]), 64'(32'hA0 + 32'(k)));
      end
      chk("t1_cap_len", 64'(cap_len), 16);
      chk("t1_truncated", 64'(truncated), 0);
      end_capture();

      stall_at   = log_addr.size() + 1;
      stall_left = 3;
      run_packet(32'h1000, 64, 0, 4, 32'hA0, snap);
      chk("t2_stall_applied", 64'(stall_left), 0);
      chk("t2_writes", 64'(log_addr.size() - snap), 4);
      chk("t2_last_data", 64'(log_data[snap + 3]), 32'hA3);
      chk("t2_cap_len", 64'(cap_len), 16);
      end_capture();

      run_packet(32'h4000, 8, 0, 5, 32'hB0, snap);
      chk("t3_writes", 64'(log_addr.size() - snap), 2);
      chk("t3_data1", 64'(log_data[snap + 1]), 32'hB1);
      chk("t3_cap_len", 64'(cap_len), 8);
      chk("t3_truncated", 64'(truncated), 1);
      end_capture();

      run_packet(32'h5000, 64, 3, 2, 32'hD0, snap);
      chk("t4_writes", 64'(log_addr.size() - snap), 2);
      chk("t4_first_addr", 64'(log_addr[snap]), 32'h5000);
      chk("t4_first_data", 64'(log_data[snap]), 32'hD0);
      chk("t4_cap_len", 64'(cap_len), 8);
      end_capture();

      snap = log_addr.size();
      cfg_write_addr = 32'h2000; cfg_max_len = 64; cfg_control = 32'h4;
      tick();
      hold_wr = 1'b1;
      send_beat(32'h55, 1'b1, 1'b0);
      bus.st_valid = 1'b1; bus.st_data = 32'h66;
      cfg_control = 32'h8;
      repeat (3) tick();
      chk("t5_stalled_state", 64'(state), 2);
      chk("t5_stalled_ready", 64'(bus.st_ready), 0);
      chk("t5_stalled_write", 64'(bus.m_write), 1);
      hold_wr = 1'b0;
      wait_state(2'd0, 20, "t5_abort_idle");
      bus.st_valid = 1'b0;
      repeat (5) tick();
      chk("t5_writes", 64'(log_addr.size() - snap), 1);
      chk("t5_data", 64'(log_data[snap]), 32'h55);
      cfg_control = 32'h0;
      tick();

      cfg_write_addr = 32'h3000; cfg_max_len = 64; cfg_control = 32'h4;
      tick();
      send_beat(32'h77, 1'b1, 1'b0);
      send_beat(32'h78, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      chk("t6_rst_state", 64'(state), 0);
      chk("t6_rst_m_write", 64'(bus.m_write), 0);
      chk("t6_rst_cap_len", 64'(cap_len), 0);
      chk("t6_rst_ready", 64'(bus.st_ready), 0);
      cfg_control = 32'h0;
      reset = 1'b1;
      tick();
      run_packet(32'h3000, 64, 0, 1, 32'h99, snap);
      repeat (5) tick();
      chk("t6_hold_done", 64'(state), 3);
      chk("t6_single_len", 64'(cap_len), 4);
      end_capture();

      rand_wr = 1'b1;
      for (int it = 0; it < 40; it++) begin
         int len, junk;
         bit do_abort;
         len      = $urandom_range(1, 10);
         junk     = $urandom_range(0, 2);
         do_abort = ($urandom_range(0, 5) == 0);
         cfg_write_addr = $urandom_range(0, 32'h0FFF_FFFF) & ~32'h3;
         cfg_max_len    = 4 * $urandom_range(0, 8);
         cfg_control    = 32'h4;
         tick();
         for (int j = 0; j < junk; j++) send_beat($urandom, 1'b0, 1'($urandom_range(0, 1)));
         for (int k = 0; k < len; k++) begin
            if (do_abort && k == len / 2) break;
            send_beat($urandom, k == 0, k == len - 1);
            cfg_write_addr = $urandom;
            cfg_max_len    = $urandom;
            if ($urandom_range(0, 3) == 0) tick();
         end
         if (do_abort) begin
            cfg_control = 32'h8;
            wait_state(2'd0, 100, "rand_abort_idle");
         end else begin
            wait_state(2'd3, 200, "rand_done");
         end
         cfg_control = 32'h0;
         tick();
         wait_state(2'd0, 10, "rand_idle");
      end
      rand_wr = 1'b0;
      tick();

      checks   += mon_checks;
      failures += mon_fails;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
